// File: rtl/j_jump.sv
// Jump-decode stage: resolves J/JAL/JR/JALR targets, link address and target-range error,
// registering all results one clock after an en=1 sample.
module j_jump #(
  parameter int unsigned PC_W   = 9,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [INST_W-1:0] inst_reg,
  input  logic [PC_W-1:0]   PC,
  input  logic [INST_W-1:0] reg_1,
  output logic [PC_W-1:0]   new_PC,
  output logic [PC_W-1:0]   J_out,
  output logic              jump_taken,
  output logic              link_valid,
  output logic              addr_err
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned TGT_MSB = 25;

  localparam logic [OP_W-1:0] OP_J    = 6'b000001;
  localparam logic [OP_W-1:0] OP_JR   = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;
  localparam logic [OP_W-1:0] OP_JALR = 6'b000100;

  logic [OP_W-1:0] opcode;
  logic [PC_W-1:0] pc_inc;
  logic            direct_hi;
  logic            reg_hi;

  logic [PC_W-1:0] nxt_pc;
  logic [PC_W-1:0] nxt_link;
  logic            nxt_taken;
  logic            nxt_link_valid;
  logic            nxt_err;

  assign opcode    = inst_reg[OP_LSB +: OP_W];
  assign pc_inc    = PC + PC_W'(1);
  // Target bits that do not fit in the PC are dropped but flagged.
  assign direct_hi = |inst_reg[TGT_MSB:PC_W];
  assign reg_hi    = |reg_1[INST_W-1:PC_W];

  // Decode of the sampled instruction.
  always_comb begin
    nxt_pc         = pc_inc;
    nxt_link       = '0;
    nxt_taken      = 1'b0;
    nxt_link_valid = 1'b0;
    nxt_err        = 1'b0;
    unique case (opcode)
      OP_J: begin
        nxt_pc    = inst_reg[PC_W-1:0];
        nxt_taken = 1'b1;
        nxt_err   = direct_hi;
      end
      OP_JAL: begin
        nxt_pc         = inst_reg[PC_W-1:0];
        nxt_link       = pc_inc;
        nxt_taken      = 1'b1;
        nxt_link_valid = 1'b1;
        nxt_err        = direct_hi;
      end
      OP_JR: begin
        nxt_pc    = reg_1[PC_W-1:0];
        nxt_taken = 1'b1;
        nxt_err   = reg_hi;
      end
      OP_JALR: begin
        nxt_pc         = reg_1[PC_W-1:0];
        nxt_link       = pc_inc;
        nxt_taken      = 1'b1;
        nxt_link_valid = 1'b1;
        nxt_err        = reg_hi;
      end
      default: ;
    endcase
  end

  // Output registers; reset wins over en, en=0 holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      new_PC     <= '0;
      J_out      <= '0;
      jump_taken <= 1'b0;
      link_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (en) begin
      new_PC     <= nxt_pc;
      J_out      <= nxt_link;
      jump_taken <= nxt_taken;
      link_valid <= nxt_link_valid;
      addr_err   <= nxt_err;
    end
  end

endmodule

// File: tb/tb_j_jump.sv
// Scoreboard bench for j_jump: stimulus pushes reference-model results, a monitor pops and
// compares them against the registered outputs each cycle.
module tb_j_jump;

  localparam int unsigned PC_W   = 9;
  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_MOD = 1 << PC_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [INST_W-1:0] inst_reg = '0;
  logic [PC_W-1:0]   PC = '0;
  logic [INST_W-1:0] reg_1 = '0;
  logic [PC_W-1:0]   new_PC;
  logic [PC_W-1:0]   J_out;
  logic              jump_taken;
  logic              link_valid;
  logic              addr_err;

  j_jump #(.PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inst_reg(inst_reg), .PC(PC), .reg_1(reg_1),
    .new_PC(new_PC), .J_out(J_out), .jump_taken(jump_taken), .link_valid(link_valid),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int unsigned npc;
    int unsigned jout;
    bit          jt;
    bit          lv;
    bit          ae;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t model;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: what the outputs should hold after the next edge, from the instruction rules.
  task automatic drive(input bit r, input bit e, input logic [31:0] ins,
                       input logic [8:0] pc, input logic [31:0] r1, input string nm);
    int unsigned op, nxt;
    @(posedge clk);
    #1;
    rst_n = r; en = e; inst_reg = ins; PC = pc; reg_1 = r1;
    op  = ins >> 26;
    nxt = (int'(pc) + 1) % PC_MOD;
    if (!r) begin
      model.npc = 0; model.jout = 0; model.jt = 0; model.lv = 0; model.ae = 0;
    end else if (e) begin
      if (op == 1 || op == 3) begin
        model.npc = ins % PC_MOD;
        model.ae  = ((ins % (1 << 26)) / PC_MOD) != 0;
        model.jt  = 1;
        model.lv  = (op == 3);
        model.jout = (op == 3) ? nxt : 0;
      end else if (op == 2 || op == 4) begin
        model.npc = r1 % PC_MOD;
        model.ae  = (r1 / PC_MOD) != 0;
        model.jt  = 1;
        model.lv  = (op == 4);
        model.jout = (op == 4) ? nxt : 0;
      end else begin
        model.npc = nxt; model.jout = 0; model.jt = 0; model.lv = 0; model.ae = 0;
      end
    end
    model.due  = cyc + 1;
    model.name = nm;
    q.push_back(model);
  endtask

  // Monitor: compare once the registered result for a queued entry is visible.
  initial begin
    exp_t x;
    logic [20:0] act, req;
    forever begin
      @(posedge clk);
      #3;
      while (q.size() > 0 && q[0].due <= cyc) begin
        x = q.pop_front();
        act = {new_PC, J_out, jump_taken, link_valid, addr_err};
        req = {PC_W'(x.npc), PC_W'(x.jout), x.jt, x.lv, x.ae};
        total++;
        if (act !== req || x.due != cyc) begin
          bad++;
          $display("FAIL %s cyc=%0d got npc=%0h jout=%0h jt=%b lv=%b ae=%b want npc=%0h jout=%0h jt=%b lv=%b ae=%b",
                   x.name, cyc, new_PC, J_out, jump_taken, link_valid, addr_err,
                   x.npc, x.jout, x.jt, x.lv, x.ae);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins, r1;
    logic [8:0]  pc;
    int unsigned sel;
    model = '{0, 0, 0, 0, 0, 0, "init"};
    drive(0, 0, 32'h0, 9'h0, 32'h0, "reset0");
    drive(0, 1, 32'h0C000003, 9'h5, 32'h0, "reset_over_en");
    drive(1, 1, 32'h04000003, 9'h1, 32'h1, "j_basic");
    drive(1, 1, 32'h0C000003, 9'h1, 32'h1, "jal_basic");
    drive(1, 1, 32'h10000000, 9'h1FF, 32'h00000205, "jalr_wrap_err");
    drive(1, 1, 32'h80000000, 9'h7, 32'h0, "nonjump");
    drive(1, 1, 32'h80000000, 9'h1FF, 32'h0, "nonjump_wrap");
    drive(1, 1, 32'h08000000, 9'h3, 32'h000001FF, "jr_max");
    drive(1, 1, 32'h08000000, 9'h3, 32'h00010001, "jr_err");
    drive(1, 1, 32'h07FFFE05, 9'h3, 32'h0, "j_direct_err");
    drive(1, 1, 32'h10000000, 9'h2A, 32'h0000002A, "jalr_self");
    drive(1, 1, 32'h0C000010, 9'h20, 32'h0, "jal_hold_src");
    for (int i = 0; i < 3; i++)
      drive(1, 0, $urandom, 9'($urandom), $urandom, "en0_hold");
    drive(0, 1, 32'h04000011, 9'h4, 32'h0, "reset_mid");
    drive(1, 0, 32'h04000011, 9'h4, 32'h0, "post_reset_idle");
    drive(1, 1, 32'h04000011, 9'h4, 32'h0, "post_reset_first");
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: ins = {6'b000001, 26'($urandom)};
        1: ins = {6'b000011, 26'($urandom)};
        2: ins = {6'b000010, 26'($urandom)};
        3: ins = {6'b000100, 26'($urandom)};
        default: ins = $urandom;
      endcase
      if ($urandom_range(0, 1) == 0) ins[25:9] = '0;
      r1 = ($urandom_range(0, 1) == 0) ? {23'd0, 9'($urandom)} : $urandom;
      pc = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom);
      drive($urandom_range(0, 29) != 0, $urandom_range(0, 4) != 0, ins, pc, r1, "random");
    end
    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending entries want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
